// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/grant/response, redirect and decode handshake.
// master is the fetch unit side; slave is the memory/decoder/backend side.
interface instr_fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic        ready_i;
   logic        is_branch_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_o, pc_o, valid_o, is_branch_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_o, pc_o, valid_o, is_branch_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem fetch and a 2-entry decode FIFO.
// Define FETCH_PREDECODE_EN to store a per-entry beq hint driving is_branch_o.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {StIdle, StWait, StWaitDrop} state_e;

   state_e            state_q;
   logic [31:0]       pc_q;
   logic [31:0]       req_pc_q;
   logic [1:0]        count_q, count_d;
   logic [1:0][31:0]  instr_q, instr_d;
   logic [1:0][31:0]  epc_q, epc_d;
`ifdef FETCH_PREDECODE_EN
   logic [1:0]        br_q, br_d;
`endif

   logic        req;
   logic        push;
   logic        pop;
   logic        wr_slot;
   logic [31:0] redirect_tgt;

   assign redirect_tgt = bus.redirect_pc_i & 32'hFFFF_FFFC;
   assign req  = (state_q == StIdle) && !bus.redirect_i && (count_q < 2'd2) && !rst_i;
   assign push = (state_q == StWait) && bus.imem_rvalid_i && !bus.redirect_i;
   assign pop  = (count_q != 2'd0) && bus.ready_i && !bus.redirect_i;

   assign bus.imem_req_o  = req;
   assign bus.imem_addr_o = pc_q;
   assign bus.valid_o     = (count_q != 2'd0);
   assign bus.instr_o     = instr_q[0];
   assign bus.pc_o        = epc_q[0];
`ifdef FETCH_PREDECODE_EN
   assign bus.is_branch_o = br_q[0];
`else
   assign bus.is_branch_o = 1'b0;
`endif

   // Entry 0 is always the head; a push lands just behind the post-pop head.
   always_comb begin
      instr_d = instr_q;
      epc_d   = epc_q;
      count_d = count_q;
`ifdef FETCH_PREDECODE_EN
      br_d    = br_q;
`endif
      wr_slot = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
      if (bus.redirect_i) begin
         count_d = 2'd0;
      end else begin
         if (pop) begin
            instr_d[0] = instr_q[1];
            epc_d[0]   = epc_q[1];
`ifdef FETCH_PREDECODE_EN
            br_d[0]    = br_q[1];
`endif
         end
         if (push) begin
            instr_d[wr_slot] = bus.imem_rdata_i;
            epc_d[wr_slot]   = req_pc_q;
`ifdef FETCH_PREDECODE_EN
            br_d[wr_slot]    = (bus.imem_rdata_i[31:26] == 6'd4);
`endif
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         count_q  <= 2'd0;
         instr_q  <= '0;
         epc_q    <= '0;
`ifdef FETCH_PREDECODE_EN
         br_q     <= '0;
`endif
      end else begin
         count_q <= count_d;
         instr_q <= instr_d;
         epc_q   <= epc_d;
`ifdef FETCH_PREDECODE_EN
         br_q    <= br_d;
`endif
         if (bus.redirect_i) begin
            pc_q <= redirect_tgt;
         end else if (req && bus.imem_gnt_i) begin
            pc_q <= pc_q + 32'd4;
         end
         unique case (state_q)
            StIdle: begin
               if (req && bus.imem_gnt_i) begin
                  state_q  <= StWait;
                  req_pc_q <= pc_q;
               end
            end
            // A response arriving with the redirect retires the request, so no drop is pending.
            StWait: begin
               if (bus.imem_rvalid_i) begin
                  state_q <= StIdle;
               end else if (bus.redirect_i) begin
                  state_q <= StWaitDrop;
               end
            end
            StWaitDrop: begin
               if (bus.imem_rvalid_i) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
